// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - serial perceptron evaluator with saturating accumulator and optional learning rule
// Learning logic (UPDATE state, train/target capture) is built only when PERCEPTRON_TRAIN_EN is defined.
module perceptron_trainer #(
   parameter int N_IN = 8,
   parameter int WW   = 4,
   parameter int AW   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_IN-1:0]         in,
   input  logic signed [AW-1:0]    threshold,
   input  logic                    start,
   input  logic                    train,
   input  logic                    target,
   input  logic                    w_we,
   input  logic [$clog2(N_IN)-1:0] w_addr,
   input  logic signed [WW-1:0]    w_data,
   output logic                    busy,
   output logic                    done,
   output logic                    result,
   output logic signed [AW-1:0]    acc,
   output logic                    updated
);
   localparam int IW = $clog2(N_IN);
   localparam logic signed [AW:0] ACC_MAX = {2'b00, {(AW-1){1'b1}}};
   localparam logic signed [AW:0] ACC_MIN = {2'b11, {(AW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ACCUM, COMPARE, UPDATE, DONE} state_t;

   state_t                  state;
   logic signed [WW-1:0]    w [N_IN];
   logic [N_IN-1:0]         in_q;
   logic signed [AW-1:0]    thr_q;
   logic [IW-1:0]           idx;
   logic signed [AW:0]      sum;
   logic signed [AW-1:0]    acc_next;
   logic                    fire;

`ifdef PERCEPTRON_TRAIN_EN
   localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
   localparam logic signed [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};
   logic train_q;
   logic tgt_q;
`else
   logic unused_train;
   assign unused_train = train ^ target;
`endif

   // One extra headroom bit makes the overflow check a plain signed compare.
   always_comb begin
      sum = {acc[AW-1], acc} + {{(AW+1-WW){w[idx][WW-1]}}, w[idx]};
      if (sum > ACC_MAX)
         acc_next = ACC_MAX[AW-1:0];
      else if (sum < ACC_MIN)
         acc_next = ACC_MIN[AW-1:0];
      else
         acc_next = sum[AW-1:0];
   end

   assign fire = (acc >= thr_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 1'b0;
         acc     <= '0;
         updated <= 1'b0;
         idx     <= '0;
         in_q    <= '0;
         thr_q   <= '0;
         for (int i = 0; i < N_IN; i++)
            w[i] <= '0;
`ifdef PERCEPTRON_TRAIN_EN
         train_q <= 1'b0;
         tgt_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (w_we && (int'(w_addr) < N_IN))
                  w[w_addr] <= w_data;
               if (start) begin
                  in_q    <= in;
                  thr_q   <= threshold;
`ifdef PERCEPTRON_TRAIN_EN
                  train_q <= train;
                  tgt_q   <= target;
`endif
                  acc     <= '0;
                  idx     <= '0;
                  updated <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_q[idx])
                  acc <= acc_next;
               idx <= idx + IW'(1);
               if (idx == IW'(N_IN - 1))
                  state <= COMPARE;
            end
            COMPARE: begin
               result <= fire;
`ifdef PERCEPTRON_TRAIN_EN
               if (train_q && (fire != tgt_q))
                  state <= UPDATE;
               else
                  state <= DONE;
`else
               state <= DONE;
`endif
            end
            UPDATE: begin
`ifdef PERCEPTRON_TRAIN_EN
               for (int i = 0; i < N_IN; i++) begin
                  if (in_q[i]) begin
                     if (tgt_q && (w[i] != W_MAX))
                        w[i] <= w[i] + WW'(1);
                     else if (!tgt_q && (w[i] != W_MIN))
                        w[i] <= w[i] - WW'(1);
                  end
               end
               updated <= 1'b1;
`endif
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - directed self-checking bench for perceptron_trainer (AW=8 and AW=6 instances)
// Expectations follow PERCEPTRON_TRAIN_EN as defined for the build.
module tb_perceptron_trainer;
`ifdef PERCEPTRON_TRAIN_EN
   localparam bit TE = 1'b1;
`else
   localparam bit TE = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic [7:0]        vin;
   logic signed [7:0] thr;
   logic signed [5:0] thr6;
   logic              start, train, target, w_we;
   logic [2:0]        w_addr;
   logic signed [3:0] w_data;
   logic              busy, done, result, updated;
   logic signed [7:0] acc;
   logic              busy6, done6, result6, updated6;
   logic signed [5:0] acc6;

   int n_cmp = 0;
   int n_err = 0;
   int lat, ndone, acc_o, acc6_o, res_o, res6_o, upd_o, tmp;
   logic busy_at [1:24];

   perceptron_trainer #(.N_IN(8), .WW(4), .AW(8)) dut (
      .clk(clk), .reset(reset), .in(vin), .threshold(thr), .start(start),
      .train(train), .target(target), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .busy(busy), .done(done), .result(result), .acc(acc), .updated(updated)
   );

   perceptron_trainer #(.N_IN(8), .WW(4), .AW(6)) dut6 (
      .clk(clk), .reset(reset), .in(vin), .threshold(thr6), .start(start),
      .train(train), .target(target), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .busy(busy6), .done(done6), .result(result6), .acc(acc6), .updated(updated6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_w(input int a, input int d);
      w_we = 1'b1; w_addr = 3'(a); w_data = 4'(d);
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   // Launch one evaluation, scramble the inputs afterwards, and watch 24 cycles.
   task automatic run(input logic [7:0] v, input int t, input int t6, input logic tr,
                      input logic tg, input int restart_at, input int wwe_at);
      vin = v; thr = 8'(t); thr6 = 6'(t6); train = tr; target = tg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; vin = ~v; thr = ~thr; thr6 = ~thr6; train = ~tr; target = ~tg;
      lat = -1; ndone = 0;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         busy_at[c] = busy;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = c; acc_o = acc; res_o = result; upd_o = updated;
               acc6_o = acc6; res6_o = result6;
            end
         end
         start = (c == restart_at);
         w_we = (c == wwe_at); w_addr = 3'd1; w_data = 4'sd5;
      end
      start = 1'b0; w_we = 1'b0;
   endtask

   task automatic read_w(input int i, output int val);
      run(8'(1 << i), -128, -32, 1'b0, 1'b0, 0, 0);
      val = acc_o;
   endtask

   initial begin
      reset = 1'b1; vin = '0; thr = '0; thr6 = '0; start = 1'b0; train = 1'b0;
      target = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_acc", acc, 0);
      check("rst_updated", updated, 0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      run(8'hFF, 0, 0, 1'b0, 1'b0, 0, 0);
      check("zero_lat", lat, 10);
      check("zero_acc", acc_o, 0);
      check("zero_res", res_o, 1);
      check("zero_busy1", busy_at[1], 1);
      check("zero_busy9", busy_at[9], 1);
      check("zero_busy10", busy_at[10], 0);
      check("zero_ndone", ndone, 1);
      check("zero_hold_res", result, 1);
      check("zero_acc6", acc6_o, 0);

      for (int i = 0; i < 8; i++) write_w(i, 7);
      run(8'hFF, 50, 31, 1'b0, 1'b0, 0, 0);
      check("pos_acc", acc_o, 56);
      check("pos_res", res_o, 1);
      check("pos_acc6_sat", acc6_o, 31);
      check("pos_res6", res6_o, 1);
      check("pos_hold_acc", acc, 56);

      for (int i = 0; i < 8; i++) write_w(i, -8);
      run(8'hFF, -63, -32, 1'b0, 1'b0, 0, 0);
      check("neg_acc", acc_o, -64);
      check("neg_res", res_o, 0);
      check("neg_acc6_sat", acc6_o, -32);
      check("neg_res6", res6_o, 1);

      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      run(8'h0F, 1, 1, 1'b1, 1'b1, 0, 0);
      check("train1_acc", acc_o, 0);
      check("train1_res", res_o, 0);
      check("train1_upd", upd_o, int'(TE));
      check("train1_lat", lat, TE ? 11 : 10);
      run(8'h0F, 1, 1, 1'b1, 1'b1, 0, 0);
      check("train2_acc", acc_o, TE ? 4 : 0);
      check("train2_res", res_o, int'(TE));
      check("train2_upd", upd_o, 0);
      check("train2_lat", lat, 10);
      read_w(0, tmp); check("train_w0", tmp, int'(TE));
      read_w(3, tmp); check("train_w3", tmp, int'(TE));
      read_w(4, tmp); check("train_w4", tmp, 0);

      write_w(0, 7);
      run(8'h01, 100, 31, 1'b1, 1'b1, 0, 0);
      check("satp_lat", lat, TE ? 11 : 10);
      check("satp_upd", upd_o, int'(TE));
      read_w(0, tmp); check("satp_w0", tmp, 7);
      write_w(0, -8);
      run(8'h01, -100, -31, 1'b1, 1'b0, 0, 0);
      check("satn_acc", acc_o, -8);
      check("satn_lat", lat, TE ? 11 : 10);
      read_w(0, tmp); check("satn_w0", tmp, -8);

      run(8'h03, 0, 0, 1'b0, 1'b0, 3, 5);
      check("busy_ndone", ndone, 1);
      check("busy_lat", lat, 10);
      check("busy_acc", acc_o, TE ? -7 : -8);
      read_w(1, tmp); check("busy_wwe_w1", tmp, int'(TE));

      vin = 8'hFF; thr = '0; thr6 = '0; train = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_acc", acc, 0);
      check("abort_done", done, 0);
      @(negedge clk); reset = 1'b1;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort_ndone", ndone, 0);
      read_w(0, tmp); check("abort_w0", tmp, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
